// File: rtl/pc_pkg.sv
// Shared operation encoding for the fetch-stage program counter.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_NEXT   = 3'd0,
        PC_HOLD   = 3'd1,
        PC_JUMP   = 3'd2,
        PC_BRANCH = 3'd3,
        PC_CALL   = 3'd4,
        PC_RET    = 3'd5
    } pc_op_t;

    // Encodings from this value upward are reserved and execute as PC_NEXT.
    localparam logic [2:0] PC_OP_RSVD_FIRST = 3'd6;

endpackage

// File: rtl/pc_return_stack.sv
// Register-array LIFO holding return addresses; push when full and pop when empty are ignored.
module pc_return_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           sync_rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               push_data,
    output logic [WIDTH-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;

    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + 1'b1;
        end else if (do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (!sync_rst && do_push) begin
            mem_q[AW'(count_q)] <= push_data;
        end
    end

    assign top   = empty ? '0 : mem_q[AW'(count_q - 1'b1)];
    assign count = count_q;

endmodule

// File: rtl/program_counter_stack.sv
// Fetch-stage program counter with relative branch, hold and call/return via a LIFO stack.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int unsigned          WIDTH        = 8,
    parameter int unsigned          STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0]     RESET_VECTOR = '0
) (
    input  logic                               clk,
    input  logic                               sync_rst,
    input  logic                               clk_en,
    input  logic [2:0]                         op,
    input  logic [WIDTH-1:0]                   target,
    input  logic [WIDTH-1:0]                   offset,
    output logic [WIDTH-1:0]                   pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               overflow,
    output logic                               underflow
);

    logic [WIDTH-1:0] pc_q, pc_d, pc_inc, stk_top;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             push, pop, full, empty;
    pc_op_t           op_e;

    assign pc_inc = pc_q + 1'b1;
    assign op_e   = (op >= PC_OP_RSVD_FIRST) ? PC_NEXT : pc_op_t'(op);

    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        pop   = 1'b0;
        if (clk_en) begin
            case (op_e)
                PC_NEXT:   pc_d = pc_inc;
                PC_HOLD:   pc_d = pc_q;
                PC_JUMP:   pc_d = target;
                PC_BRANCH: pc_d = pc_q + offset;
                PC_CALL: begin
                    if (full) begin
                        pc_d  = pc_inc;
                        ovf_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        pc_d = target;
                    end
                end
                PC_RET: begin
                    if (empty) begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stk_top;
                    end
                end
                default:   pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            pc_q  <= RESET_VECTOR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .count     (stack_count),
        .full      (full),
        .empty     (empty)
    );

    assign pc          = pc_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed-vector bench for program_counter_stack with hand-computed expectations.
module tb_program_counter_stack;

    logic       clk = 1'b0;
    logic       sync_rst, clk_en;
    logic [2:0] op;
    logic [7:0] target, offset, pc;
    logic [2:0] stack_count;
    logic       stack_full, stack_empty, overflow, underflow;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    program_counter_stack #(
        .WIDTH        (8),
        .STACK_DEPTH  (4),
        .RESET_VECTOR (8'h10)
    ) dut (
        .clk         (clk),
        .sync_rst    (sync_rst),
        .clk_en      (clk_en),
        .op          (op),
        .target      (target),
        .offset      (offset),
        .pc          (pc),
        .stack_count (stack_count),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [2:0] o,
                        input logic [7:0] tgt, input logic [7:0] off);
        sync_rst = rst;
        clk_en   = en;
        op       = o;
        target   = tgt;
        offset   = off;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc_cnt(input string tag, input logic [7:0] epc, input logic [2:0] ecnt);
        check({tag, ".pc"}, 32'(pc), 32'(epc));
        check({tag, ".count"}, 32'(stack_count), 32'(ecnt));
    endtask

    initial begin
        sync_rst = 1'b0; clk_en = 1'b0; op = '0; target = '0; offset = '0;
        @(negedge clk);

        // Reset with clk_en low
        step(1, 0, 3'd0, 8'h00, 8'h00);
        chk_pc_cnt("rst", 8'h10, 3'd0);
        check("rst.empty", 32'(stack_empty), 32'd1);
        check("rst.full", 32'(stack_full), 32'd0);
        check("rst.ovf", 32'(overflow), 32'd0);
        check("rst.unf", 32'(underflow), 32'd0);

        // NEXT with enable toggling 1,0,1,0,1
        step(0, 1, 3'd0, 8'h00, 8'h00); check("en1.pc", 32'(pc), 32'h11);
        step(0, 0, 3'd0, 8'h00, 8'h00); check("en0.pc", 32'(pc), 32'h11);
        step(0, 1, 3'd0, 8'h00, 8'h00); check("en2.pc", 32'(pc), 32'h12);
        step(0, 0, 3'd2, 8'hEE, 8'h00); check("en0b.pc", 32'(pc), 32'h12);
        step(0, 1, 3'd0, 8'h00, 8'h00); check("en3.pc", 32'(pc), 32'h13);

        // Jump and wrap
        step(0, 1, 3'd2, 8'hFE, 8'h00); check("jmp.pc", 32'(pc), 32'hFE);
        step(0, 1, 3'd0, 8'h00, 8'h00); check("nxtFF.pc", 32'(pc), 32'hFF);
        step(0, 1, 3'd0, 8'h00, 8'h00); check("wrap.pc", 32'(pc), 32'h00);

        // Branches
        step(0, 1, 3'd2, 8'h05, 8'h00);
        step(0, 1, 3'd3, 8'h00, 8'hFC); check("brneg.pc", 32'(pc), 32'h01);
        step(0, 1, 3'd3, 8'h00, 8'h00); check("br0.pc", 32'(pc), 32'h01);
        step(0, 1, 3'd1, 8'h00, 8'h00); check("hold.pc", 32'(pc), 32'h01);
        step(0, 1, 3'd2, 8'h90, 8'h00);
        step(0, 1, 3'd3, 8'h00, 8'h7F); check("brpos.pc", 32'(pc), 32'h0F);

        // Nested calls
        step(0, 1, 3'd2, 8'h20, 8'h00);
        step(0, 1, 3'd4, 8'h40, 8'h00); chk_pc_cnt("call1", 8'h40, 3'd1);
        step(0, 1, 3'd4, 8'h60, 8'h00); chk_pc_cnt("call2", 8'h60, 3'd2);
        step(0, 1, 3'd5, 8'h00, 8'h00); chk_pc_cnt("ret1", 8'h41, 3'd1);
        step(0, 1, 3'd5, 8'h00, 8'h00); chk_pc_cnt("ret2", 8'h21, 3'd0);
        check("ret2.empty", 32'(stack_empty), 32'd1);

        // Fill the stack, then overflow
        step(0, 1, 3'd2, 8'h00, 8'h00);
        step(0, 1, 3'd4, 8'h10, 8'h00);
        step(0, 1, 3'd4, 8'h20, 8'h00);
        step(0, 1, 3'd4, 8'h30, 8'h00);
        step(0, 1, 3'd4, 8'h4F, 8'h00); chk_pc_cnt("fill", 8'h4F, 3'd4);
        check("fill.full", 32'(stack_full), 32'd1);
        step(0, 1, 3'd0, 8'h00, 8'h00);
        step(0, 1, 3'd4, 8'hAA, 8'h00); chk_pc_cnt("ovf", 8'h51, 3'd4);
        check("ovf.flag", 32'(overflow), 32'd1);
        step(0, 1, 3'd5, 8'h00, 8'h00); chk_pc_cnt("pop4", 8'h31, 3'd3);
        step(0, 1, 3'd5, 8'h00, 8'h00); chk_pc_cnt("pop3", 8'h21, 3'd2);
        step(0, 1, 3'd5, 8'h00, 8'h00); chk_pc_cnt("pop2", 8'h11, 3'd1);
        step(0, 1, 3'd5, 8'h00, 8'h00); chk_pc_cnt("pop1", 8'h01, 3'd0);
        check("pop1.ovf", 32'(overflow), 32'd1);

        // Underflow, then stack still usable
        step(0, 1, 3'd2, 8'h30, 8'h00);
        step(0, 1, 3'd5, 8'h00, 8'h00); chk_pc_cnt("unf", 8'h31, 3'd0);
        check("unf.flag", 32'(underflow), 32'd1);
        step(0, 1, 3'd4, 8'h70, 8'h00); chk_pc_cnt("unf.call", 8'h70, 3'd1);
        step(0, 1, 3'd5, 8'h00, 8'h00); chk_pc_cnt("unf.ret", 8'h32, 3'd0);
        check("unf.sticky", 32'(underflow), 32'd1);

        // Mid-operation reset with CALL on op
        step(0, 1, 3'd4, 8'h80, 8'h00);
        step(0, 1, 3'd4, 8'h90, 8'h00);
        step(0, 1, 3'd4, 8'hA0, 8'h00); chk_pc_cnt("pre.rst", 8'hA0, 3'd3);
        step(1, 1, 3'd4, 8'hC0, 8'h00); chk_pc_cnt("mid.rst", 8'h10, 3'd0);
        check("mid.rst.ovf", 32'(overflow), 32'd0);
        check("mid.rst.unf", 32'(underflow), 32'd0);

        // Reserved ops execute as NEXT; disabled RET leaves flags alone
        step(0, 1, 3'd7, 8'h55, 8'h33); check("rsv7.pc", 32'(pc), 32'h11);
        step(0, 1, 3'd6, 8'h55, 8'h33); check("rsv6.pc", 32'(pc), 32'h12);
        step(0, 0, 3'd5, 8'h00, 8'h00); chk_pc_cnt("dis.ret", 8'h12, 3'd0);
        check("dis.ret.unf", 32'(underflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
Parametrised program counter for the core fetch stage. Replaces the fixed 8-bit counter-with-overwrite.
- Adds relative branch, hold, and call/return through an internal LIFO return-address stack.
- Reports stack status and sticky error flags.
- Drives the instruction-memory address and is sequenced one operation per enabled clock by the decode/control block.

Parameters:
WIDTH, 8, PC and address width in bits (>= 2)
STACK_DEPTH, 4, number of return-address entries (>= 1)
RESET_VECTOR, 0, PC value loaded on sync_rst (WIDTH bits)

Ports:
clk  in  1  single clock, rising edge
sync_rst  in  1  synchronous active-high reset
clk_en  in  1  advance enable; low = all state held
op  in  3  operation select, pc_op_t
target  in  WIDTH  absolute address for JUMP/CALL
offset  in  WIDTH  signed two's-complement displacement for BRANCH
pc  out  WIDTH  current program counter
stack_count  out  $clog2(STACK_DEPTH+1)  valid stack entries
stack_full  out  1  stack_count == STACK_DEPTH
stack_empty  out  1  stack_count == 0
overflow  out  1  sticky: CALL attempted while full
underflow  out  1  sticky: RET attempted while empty

Behaviour:
Interface decision: one clock `clk`; reset is synchronous and active-high (`sync_rst`).

Reset and enable:
- sync_rst high at a rising edge: pc = RESET_VECTOR, stack_count = 0, overflow = underflow = 0. Stack contents are don't-care.
- sync_rst has priority over clk_en and op, and acts even when clk_en is low.
- clk_en low, sync_rst low: pc, stack, and flags all hold; op is ignored.

Timing:
- All updates are registered. The effect of op is visible on pc the cycle after the enabled edge; latency is 1, throughput 1 op per enabled cycle.
- Outputs are registered state or pure decode of registered state. No combinational path from inputs to outputs.
- All PC arithmetic is modulo 2^WIDTH. Wrap is silent and not an error.

Ops, with clk_en high:
- NEXT (0): pc <= pc+1.
- HOLD (1): pc unchanged.
- JUMP (2): pc <= target.
- BRANCH (3): pc <= pc + offset, where offset is signed and relative to the current pc. offset = 0 behaves as HOLD.
- CALL (4):
  - If not full: push pc+1 (wrapped), then pc <= target, stack_count+1.
  - If full: no push, pc <= pc+1, overflow <= 1.
- RET (5):
  - If not empty: pc <= top entry, pop, stack_count-1.
  - If empty: pc <= pc+1, underflow <= 1.
- 6, 7 are reserved and execute as NEXT.

Flags:
- overflow and underflow clear only on sync_rst.
- A CALL immediately followed by RET returns to the address after the CALL.
- Stack ordering is strict LIFO. A push and a pop never occur in the same cycle.

Decomposition:
- Package pc_pkg: typedef enum logic [2:0] pc_op_t {PC_NEXT, PC_HOLD, PC_JUMP, PC_BRANCH, PC_CALL, PC_RET}, plus the reserved-value localparam.
- Sub-module pc_return_stack:
  - Parameters WIDTH, DEPTH.
  - Ports clk, sync_rst, push, pop, push_data, top, count, full, empty.
  - Register-array LIFO. Ignores push when full and pop when empty.
- Top level: op decode, next-pc mux, and flags.

Test Plan (WIDTH=8, STACK_DEPTH=4, RESET_VECTOR=8'h10):
- Reset and enable: sync_rst pulse with clk_en=0 -> pc=8'h10, count=0, empty=1, flags 0. Then NEXT x3 with clk_en toggling 1,0,1,0,1 -> pc=8'h13, unchanged on disabled cycles.
- Jump, wrap, branch:
  - JUMP 8'hFE, NEXT, NEXT -> pc 8'hFE, 8'hFF, 8'h00.
  - BRANCH offset=8'hFC from pc=8'h05 -> pc=8'h01.
  - BRANCH offset=8'h7F from 8'h90 -> 8'h0F.
- Nested calls: at pc=8'h20 CALL 8'h40; at 8'h40 CALL 8'h60; RET; RET -> pc sequence 8'h40, 8'h60, 8'h41, 8'h21, count 1, 2, 1, 0.
- Overflow: 4 CALLs (full=1), 5th CALL 8'hAA at pc=8'h50 -> pc=8'h51, overflow=1, count stays 4. Subsequent RET pops the 4th return address correctly.
- Underflow: RET with empty stack at pc=8'h30 -> pc=8'h31, underflow=1. A later valid CALL/RET works while underflow stays 1 until sync_rst.
- Mid-operation reset and reserved ops: sync_rst with count=3 and op=CALL -> pc=8'h10, count=0, flags 0. Op 3'd7 at pc=8'h10 -> pc=8'h11.
